// File: rtl/branch_encoder_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// branch_encoder_if : request/response bundle for branch_encoder.  Rev 1.0
// ----------------------------------------------------------------------------
interface branch_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_beq;
  logic        in_bne;
  logic        in_blt;
  logic        in_bge;
  logic        in_bltu;
  logic        in_bgeu;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [12:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;

  modport master (
    output in_valid, in_beq, in_bne, in_blt, in_bge, in_bltu, in_bgeu,
    output in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );

  modport slave (
    input  in_valid, in_beq, in_bne, in_blt, in_bge, in_bltu, in_bgeu,
    input  in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_err
  );
endinterface
`default_nettype wire

// File: rtl/branch_encoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// branch_encoder : packs a branch request into an RV32I B-type word, queued in
// a small output FIFO. Macro BRANCH_ENC_STATS_EN adds request counters. Rev 1.0
// ----------------------------------------------------------------------------
module branch_encoder #(
  parameter int unsigned DEPTH  = 2,
  parameter logic [6:0]  OPCODE = 7'b1100011
) (
  input  logic            clk,
  input  logic            rst_n,
`ifdef BRANCH_ENC_STATS_EN
  input  logic            stat_clr,
  output logic [15:0]     stat_ok,
  output logic [15:0]     stat_err,
`endif
  branch_encoder_if.slave bus
);
  localparam int unsigned   AW     = $clog2(DEPTH);
  localparam int unsigned   CW     = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  logic [5:0]    w_type;
  logic          w_onehot;
  logic          w_illegal;
  logic [2:0]    w_funct3;
  logic [31:0]   w_instr;
  logic          w_push;
  logic          w_pop;

  logic [32:0]   mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  assign w_type   = {bus.in_bgeu, bus.in_bltu, bus.in_bge,
                     bus.in_blt, bus.in_bne, bus.in_beq};
  assign w_onehot = (w_type != 6'd0) && ((w_type & (w_type - 6'd1)) == 6'd0);
  assign w_illegal = !w_onehot || bus.in_imm[0];

  always_comb begin
    w_funct3 = 3'b000;
    case (w_type)
      6'b000010: w_funct3 = 3'b001;
      6'b000100: w_funct3 = 3'b100;
      6'b001000: w_funct3 = 3'b101;
      6'b010000: w_funct3 = 3'b110;
      6'b100000: w_funct3 = 3'b111;
      default:   w_funct3 = 3'b000;
    endcase
  end

  assign w_instr = w_illegal ? 32'h0 :
                   {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1,
                    w_funct3, bus.in_imm[4:1], bus.in_imm[11], OPCODE};

  // in_ready depends only on registered count, never on out_ready
  assign bus.in_ready  = (count_q != C_FULL);
  assign bus.out_valid = (count_q != '0);
  assign w_push        = bus.in_valid && bus.in_ready;
  assign w_pop         = bus.out_valid && bus.out_ready;

  assign bus.out_err   = bus.out_valid ? mem_q[rd_ptr_q][32]   : 1'b0;
  assign bus.out_instr = bus.out_valid ? mem_q[rd_ptr_q][31:0] : 32'h0;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (w_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (w_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: outputs are gated by out_valid
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= {w_illegal, w_instr};
  end

`ifdef BRANCH_ENC_STATS_EN
  logic [15:0] stat_ok_q, stat_ok_d;
  logic [15:0] stat_err_q, stat_err_d;

  always_comb begin
    stat_ok_d  = stat_ok_q;
    stat_err_d = stat_err_q;
    if (stat_clr) begin
      stat_ok_d  = 16'd0;
      stat_err_d = 16'd0;
    end else if (w_push) begin
      if (w_illegal) begin
        if (stat_err_q != 16'hFFFF) stat_err_d = stat_err_q + 16'd1;
      end else begin
        if (stat_ok_q != 16'hFFFF) stat_ok_d = stat_ok_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ok_q  <= 16'd0;
      stat_err_q <= 16'd0;
    end else begin
      stat_ok_q  <= stat_ok_d;
      stat_err_q <= stat_err_d;
    end
  end

  assign stat_ok  = stat_ok_q;
  assign stat_err = stat_err_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_branch_encoder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_branch_encoder : randomized bench with a queue-based reference model.
// ----------------------------------------------------------------------------
module tb_branch_encoder;
  localparam int         DEPTH = 2;
  localparam logic [6:0] OPC   = 7'b1100011;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  branch_encoder_if bus();
`ifdef BRANCH_ENC_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_ok;
  logic [15:0] stat_err;
`endif

  branch_encoder #(.DEPTH(DEPTH), .OPCODE(OPC)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
`ifdef BRANCH_ENC_STATS_EN
    .stat_clr(stat_clr),
    .stat_ok (stat_ok),
    .stat_err(stat_err),
`endif
    .bus     (bus)
  );

  int          n_cmp;
  int          n_err;
  int          mcount;
  logic [32:0] exp_q[$];
  logic [32:0] act_q[$];

  // {err, instr} from the B-type field rules; type bit k: beq,bne,blt,bge,bltu,bgeu
  function automatic logic [32:0] ref_encode(input logic [5:0] typ, input logic [4:0] rs1,
                                             input logic [4:0] rs2, input logic [12:0] imm);
    int unsigned f3;
    logic [31:0] w;
    if ($countones(typ) != 1 || imm[0] == 1'b1) return {1'b1, 32'h0};
    f3 = 0;
    for (int k = 0; k < 6; k++) if (typ[k]) f3 = (k < 2) ? k : k + 2;
    w = {25'd0, OPC} | (32'(imm[12]) << 31) | (32'((imm >> 5) & 13'h3F) << 25)
      | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
      | (32'((imm >> 1) & 13'hF) << 8) | (32'(imm[11]) << 7);
    return {1'b0, w};
  endfunction

  task automatic set_req(input logic [5:0] typ, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [12:0] imm);
    {bus.in_bgeu, bus.in_bltu, bus.in_bge, bus.in_blt, bus.in_bne, bus.in_beq} = typ;
    bus.in_rs1 = rs1;
    bus.in_rs2 = rs2;
    bus.in_imm = imm;
  endtask

  task automatic rand_req(input bit legal_only);
    logic [5:0]  typ;
    logic [12:0] imm;
    typ = 6'(1 << $urandom_range(0, 5));
    imm = 13'($urandom);
    if (!legal_only && $urandom_range(0, 7) == 0) typ = 6'($urandom);
    if (legal_only || $urandom_range(0, 7) != 0) imm[0] = 1'b0;
    set_req(typ, 5'($urandom), 5'($urandom), imm);
  endtask

  // Advance one clock; the model decides acceptance from its own occupancy
  task automatic step();
    bit push, pop;
    push = bus.in_valid && (mcount != DEPTH);
    pop  = bus.out_ready && (mcount != 0);
    if (pop) act_q.push_back({bus.out_err, bus.out_instr});
    if (push) exp_q.push_back(ref_encode({bus.in_bgeu, bus.in_bltu, bus.in_bge, bus.in_blt,
                                          bus.in_bne, bus.in_beq},
                                         bus.in_rs1, bus.in_rs2, bus.in_imm));
    mcount = mcount + int'(push) - int'(pop);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_instr !== 32'h0) begin n_err++; $display("FAIL reset_out_instr: got %h want 0", bus.out_instr); end
    n_cmp++; if (bus.out_err !== 1'b0) begin n_err++; $display("FAIL reset_out_err: got %b want 0", bus.out_err); end
    rst_n = 1'b1;
    step();
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL post_reset_idle: valid %b ready %b want 0 1", bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_known_vectors();
    logic [32:0] a, e;
    bus.out_ready = 1'b1;
    set_req(6'b000001, 5'd1, 5'd2, 13'd8);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    n_cmp++; if ({bus.out_valid, bus.out_err, bus.out_instr} !== {2'b10, 32'h00208463}) begin
      n_err++; $display("FAIL beq_vector: got v%b e%b %h want v1 e0 00208463", bus.out_valid, bus.out_err, bus.out_instr); end
    step();
    set_req(6'b000010, 5'd5, 5'd0, 13'h1FFC);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    n_cmp++; if ({bus.out_valid, bus.out_err, bus.out_instr} !== {2'b10, 32'hFE029EE3}) begin
      n_err++; $display("FAIL bne_vector: got v%b e%b %h want v1 e0 FE029EE3", bus.out_valid, bus.out_err, bus.out_instr); end
    for (int k = 0; k < 10 && mcount != 0; k++) step();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL known_drain: out_valid %b want 0", bus.out_valid); end
    while (act_q.size() != 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (a !== e) begin n_err++; $display("FAIL known_order: got %h want %h", a, e); end
    end
  endtask

  task automatic test_backpressure();
    logic [32:0] a, e;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rand_req(1'b1);
      step();
      n_cmp++; if (bus.in_ready !== (k == 0)) begin
        n_err++; $display("FAIL bp_in_ready[%0d]: got %b want %b", k, bus.in_ready, k == 0); end
    end
    step();
    n_cmp++; if ({bus.out_err, bus.out_instr} !== exp_q[0]) begin
      n_err++; $display("FAIL bp_hold: got %h want %h", {bus.out_err, bus.out_instr}, exp_q[0]); end
    bus.out_ready = 1'b1;
    step();
    step();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 10 && mcount != 0; k++) step();
    n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_recover: ready %b valid %b want 1 0", bus.in_ready, bus.out_valid); end
    n_cmp++; if (act_q.size() != 3) begin n_err++; $display("FAIL bp_count: got %0d words want 3", act_q.size()); end
    while (act_q.size() != 0 && exp_q.size() != 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (a !== e) begin n_err++; $display("FAIL bp_order: got %h want %h", a, e); end
    end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_illegal();
    logic [32:0] a, e;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    set_req(6'b001100, 5'd3, 5'd4, 13'd8);
    step();
    n_cmp++; if ({bus.out_valid, bus.out_err, bus.out_instr} !== {2'b11, 32'h0}) begin
      n_err++; $display("FAIL illegal_twohot: got v%b e%b %h want v1 e1 0", bus.out_valid, bus.out_err, bus.out_instr); end
    set_req(6'b000001, 5'd3, 5'd4, 13'd3);
    step();
    n_cmp++; if ({bus.out_valid, bus.out_err, bus.out_instr} !== {2'b11, 32'h0}) begin
      n_err++; $display("FAIL illegal_misalign: got v%b e%b %h want v1 e1 0", bus.out_valid, bus.out_err, bus.out_instr); end
    set_req(6'b000000, 5'd7, 5'd8, 13'd16);
    step();
    n_cmp++; if ({bus.out_valid, bus.out_err, bus.out_instr} !== {2'b11, 32'h0}) begin
      n_err++; $display("FAIL illegal_none: got v%b e%b %h want v1 e1 0", bus.out_valid, bus.out_err, bus.out_instr); end
    bus.in_valid = 1'b0;
    for (int k = 0; k < 10 && mcount != 0; k++) step();
    while (act_q.size() != 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (a !== e) begin n_err++; $display("FAIL illegal_order: got %h want %h", a, e); end
    end
  endtask

  task automatic test_full_stream();
    logic [32:0] a, e;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin rand_req(1'b1); step(); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready: got %b want 0", bus.in_ready); end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rand_req(1'b0);
      step();
      n_cmp++; if (bus.in_ready !== (mcount != DEPTH) || bus.out_valid !== (mcount != 0)) begin
        n_err++; $display("FAIL stream_hs[%0d]: ready %b valid %b model count %0d", k, bus.in_ready, bus.out_valid, mcount); end
      n_cmp++; if ({bus.out_err, bus.out_instr} !== exp_q[act_q.size()]) begin
        n_err++; $display("FAIL stream_head[%0d]: got %h want %h", k, {bus.out_err, bus.out_instr}, exp_q[act_q.size()]); end
    end
    bus.in_valid = 1'b0;
    for (int k = 0; k < 10 && mcount != 0; k++) step();
    while (act_q.size() != 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (a !== e) begin n_err++; $display("FAIL stream_order: got %h want %h", a, e); end
    end
  endtask

  task automatic test_random();
    logic [32:0] a, e;
    for (int k = 0; k < 400; k++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      rand_req(1'b0);
      step();
      n_cmp++; if (bus.in_ready !== (mcount != DEPTH) || bus.out_valid !== (mcount != 0)) begin
        n_err++; $display("FAIL rand_hs[%0d]: ready %b valid %b model count %0d", k, bus.in_ready, bus.out_valid, mcount); end
      if (mcount != 0) begin
        n_cmp++; if ({bus.out_err, bus.out_instr} !== exp_q[act_q.size()]) begin
          n_err++; $display("FAIL rand_head[%0d]: got %h want %h", k, {bus.out_err, bus.out_instr}, exp_q[act_q.size()]); end
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10 && mcount != 0; k++) step();
    while (act_q.size() != 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (a !== e) begin n_err++; $display("FAIL rand_order: got %h want %h", a, e); end
    end
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int k = 0; k < 2; k++) begin rand_req(1'b1); step(); end
    bus.in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_instr !== 32'h0) begin
      n_err++; $display("FAIL async_reset: valid %b ready %b instr %h want 0 1 0", bus.out_valid, bus.in_ready, bus.out_instr); end
    exp_q.delete(); act_q.delete(); mcount = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        n_err++; $display("FAIL stale_after_reset[%0d]: valid %b ready %b want 0 1", k, bus.out_valid, bus.in_ready); end
    end
    act_q.delete();
  endtask

`ifdef BRANCH_ENC_STATS_EN
  task automatic test_stats();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin rand_req(1'b1); step(); end
    set_req(6'b000011, 5'd1, 5'd1, 13'd4);
    step();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 10 && mcount != 0; k++) step();
    n_cmp++; if (stat_ok !== 16'd3 || stat_err !== 16'd1) begin
      n_err++; $display("FAIL stats_count: ok %0d err %0d want 3 1", stat_ok, stat_err); end
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    n_cmp++; if (stat_ok !== 16'd0 || stat_err !== 16'd0) begin
      n_err++; $display("FAIL stats_clear: ok %0d err %0d want 0 0", stat_ok, stat_err); end
    act_q.delete(); exp_q.delete();
  endtask
`endif

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    mcount = 0;
    rst_n  = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    set_req(6'd0, 5'd0, 5'd0, 13'd0);
`ifdef BRANCH_ENC_STATS_EN
    stat_clr = 1'b0;
`endif
    test_reset();
    test_known_vectors();
    test_backpressure();
    test_illegal();
    test_full_stream();
    test_random();
    test_async_reset();
`ifdef BRANCH_ENC_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
